// File: rtl/uart_parity_unit.sv
// Parity generator/checker shared by the UART TX and RX paths.
module uart_parity_unit #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  PAR_EN,
  input  logic [1:0]            PAR_TYP,
  input  logic                  Load,
  input  logic [DATA_WIDTH-1:0] DATA_IN,
  output logic                  Parity_Bit,
  input  logic                  Rx_Start,
  input  logic                  Bit_Valid,
  input  logic                  Bit_In,
  output logic                  Par_Err,
  output logic                  Check_Done,
  output logic                  Rx_Busy
);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY
  } rx_state_t;

  // Parity bit for a data-word XOR x under parity type typ.
  function automatic logic par_exp(input logic x, input logic [1:0] typ);
    case (typ)
      2'b00:   return x;
      2'b01:   return ~x;
      2'b10:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_en;
  logic [1:0]            tx_typ;

  rx_state_t             state, state_n;
  logic                  acc, acc_n;
  logic [CNT_WIDTH-1:0]  cnt, cnt_n;
  logic [CNT_WIDTH-1:0]  cnt_inc;
  logic                  en_snap, en_snap_n;
  logic [1:0]            typ_snap, typ_snap_n;
  logic                  err_n;
  logic                  done_n;

  // TX word and mode are captured only on Load.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      tx_data <= '0;
      tx_en   <= 1'b0;
      tx_typ  <= 2'b00;
    end else if (Load) begin
      tx_data <= DATA_IN;
      tx_en   <= PAR_EN;
      tx_typ  <= PAR_TYP;
    end
  end

  assign Parity_Bit = tx_en ? par_exp(^tx_data, tx_typ) : 1'b0;

  // RX state and datapath registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      acc        <= 1'b0;
      cnt        <= '0;
      en_snap    <= 1'b0;
      typ_snap   <= 2'b00;
      Par_Err    <= 1'b0;
      Check_Done <= 1'b0;
    end else begin
      state      <= state_n;
      acc        <= acc_n;
      cnt        <= cnt_n;
      en_snap    <= en_snap_n;
      typ_snap   <= typ_snap_n;
      Par_Err    <= err_n;
      Check_Done <= done_n;
    end
  end

  assign cnt_inc = cnt + 1'b1;

  // RX next-state logic; Rx_Start overrides everything, including a same-cycle Bit_Valid.
  always_comb begin
    state_n    = state;
    acc_n      = acc;
    cnt_n      = cnt;
    en_snap_n  = en_snap;
    typ_snap_n = typ_snap;
    err_n      = Par_Err;
    done_n     = 1'b0;

    if (Rx_Start) begin
      state_n    = DATA;
      acc_n      = 1'b0;
      cnt_n      = '0;
      en_snap_n  = PAR_EN;
      typ_snap_n = PAR_TYP;
      err_n      = 1'b0;
    end else begin
      case (state)
        DATA: begin
          if (Bit_Valid) begin
            acc_n = acc ^ Bit_In;
            cnt_n = cnt_inc;
            if (cnt_inc == CNT_WIDTH'(DATA_WIDTH)) begin
              if (en_snap) begin
                state_n = PARITY;
              end else begin
                state_n = IDLE;
                done_n  = 1'b1;
              end
            end
          end
        end
        PARITY: begin
          if (Bit_Valid) begin
            err_n   = (Bit_In != par_exp(acc, typ_snap));
            done_n  = 1'b1;
            state_n = IDLE;
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  assign Rx_Busy = (state != IDLE);

endmodule

// File: tb/tb_uart_parity_unit.sv
// Directed bench for uart_parity_unit at DATA_WIDTH 8, 5 and 9.
module tb_uart_parity_unit;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       PAR_EN = 1'b0;
  logic [1:0] PAR_TYP = 2'b00;
  logic       Load = 1'b0;
  logic [7:0] DATA_IN = '0;
  logic [4:0] DATA_IN5 = '0;
  logic [8:0] DATA_IN9 = '0;
  logic       Rx_Start = 1'b0;
  logic       Bit_Valid = 1'b0;
  logic       Bit_In = 1'b0;

  logic pb8, err8, done8, busy8;
  logic pb5, err5, done5, busy5;
  logic pb9, err9, done9, busy9;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  always #5 CLK = ~CLK;

  uart_parity_unit #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut (
    .CLK(CLK), .RST(RST), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .Load(Load),
    .DATA_IN(DATA_IN), .Parity_Bit(pb8), .Rx_Start(Rx_Start), .Bit_Valid(Bit_Valid),
    .Bit_In(Bit_In), .Par_Err(err8), .Check_Done(done8), .Rx_Busy(busy8)
  );

  uart_parity_unit #(.DATA_WIDTH(5), .CNT_WIDTH(3)) dut5 (
    .CLK(CLK), .RST(RST), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .Load(Load),
    .DATA_IN(DATA_IN5), .Parity_Bit(pb5), .Rx_Start(Rx_Start), .Bit_Valid(Bit_Valid),
    .Bit_In(Bit_In), .Par_Err(err5), .Check_Done(done5), .Rx_Busy(busy5)
  );

  uart_parity_unit #(.DATA_WIDTH(9), .CNT_WIDTH(4)) dut9 (
    .CLK(CLK), .RST(RST), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .Load(Load),
    .DATA_IN(DATA_IN9), .Parity_Bit(pb9), .Rx_Start(Rx_Start), .Bit_Valid(Bit_Valid),
    .Bit_In(Bit_In), .Par_Err(err9), .Check_Done(done9), .Rx_Busy(busy9)
  );

  task automatic check(input string tag, input logic got, input logic exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic rx_bit(input logic b);
    Bit_Valid = 1'b1;
    Bit_In    = b;
    tick();
    Bit_Valid = 1'b0;
  endtask

  task automatic send_bits(input logic [8:0] d, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) rx_bit(d[i]);
  endtask

  task automatic rx_start;
    Rx_Start = 1'b1;
    tick();
    Rx_Start = 1'b0;
  endtask

  task automatic tx_load(input logic [7:0] d, input logic en, input logic [1:0] typ);
    DATA_IN = d;
    PAR_EN  = en;
    PAR_TYP = typ;
    Load    = 1'b1;
    tick();
    Load    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    #3;
    check("rst_pb", pb8, 1'b0);
    check("rst_err", err8, 1'b0);
    check("rst_done", done8, 1'b0);
    check("rst_busy", busy8, 1'b0);
    tick();
    RST = 1'b1;
    tick();

    // TX: A5 has four ones
    tx_load(8'hA5, 1'b1, 2'b00);
    check("tx_even_a5", pb8, 1'b0);
    PAR_TYP = 2'b01;
    tick();
    check("tx_typ_no_load", pb8, 1'b0);
    tx_load(8'hA5, 1'b1, 2'b01);
    check("tx_odd_a5", pb8, 1'b1);
    PAR_EN = 1'b0;
    tick();
    check("tx_en_no_load", pb8, 1'b1);
    tx_load(8'h00, 1'b1, 2'b10);
    check("tx_mark", pb8, 1'b1);
    tx_load(8'h00, 1'b1, 2'b11);
    check("tx_space", pb8, 1'b0);
    tx_load(8'h01, 1'b0, 2'b10);
    check("tx_disabled", pb8, 1'b0);
    tx_load(8'h01, 1'b1, 2'b00);
    check("tx_even_01", pb8, 1'b1);

    // RX even, 8'h37 has five ones -> expected parity 1
    PAR_EN = 1'b1; PAR_TYP = 2'b00;
    rx_start();
    check("rx3_busy", busy8, 1'b1);
    send_bits(9'h037, 8);
    check("rx3_in_parity_busy", busy8, 1'b1);
    check("rx3_in_parity_done", done8, 1'b0);
    rx_bit(1'b1);
    check("rx3_done", done8, 1'b1);
    check("rx3_err", err8, 1'b0);
    check("rx3_idle", busy8, 1'b0);
    tick();
    check("rx3_done_pulse", done8, 1'b0);

    rx_start();
    send_bits(9'h037, 8);
    rx_bit(1'b0);
    check("rx3b_done", done8, 1'b1);
    check("rx3b_err", err8, 1'b1);
    tick(); tick(); tick();
    check("rx3b_err_held", err8, 1'b1);
    check("rx3b_done_low", done8, 1'b0);

    // RX without parity; PAR_EN raised mid-frame must be ignored
    PAR_EN = 1'b0;
    rx_start();
    check("rx4_err_cleared", err8, 1'b0);
    PAR_EN = 1'b1;
    send_bits(9'h037, 7);
    check("rx4_pre_done", done8, 1'b0);
    check("rx4_pre_busy", busy8, 1'b1);
    rx_bit(1'b0);
    check("rx4_done", done8, 1'b1);
    check("rx4_err", err8, 1'b0);
    check("rx4_idle", busy8, 1'b0);
    rx_bit(1'b1);
    check("rx4_idle_ignore_busy", busy8, 1'b0);
    check("rx4_idle_ignore_done", done8, 1'b0);

    // Restart collides with a parity check; simultaneous Load honoured
    PAR_TYP = 2'b00;
    rx_start();
    send_bits(9'h037, 8);
    rx_bit(1'b0);
    check("rxr_setup_err", err8, 1'b1);
    rx_start();
    send_bits(9'h037, 8);
    Rx_Start = 1'b1; Bit_Valid = 1'b1; Bit_In = 1'b0;
    Load = 1'b1; DATA_IN = 8'h01;
    tick();
    Rx_Start = 1'b0; Bit_Valid = 1'b0; Load = 1'b0;
    check("rxr_no_done", done8, 1'b0);
    check("rxr_err_cleared", err8, 1'b0);
    check("rxr_busy", busy8, 1'b1);
    check("rxr_load_pb", pb8, 1'b1);
    send_bits(9'h000, 8);
    rx_bit(1'b0);
    check("rxr_frame_done", done8, 1'b1);
    check("rxr_frame_err", err8, 1'b0);

    // Restart after 4 bits with a discarded same-cycle Bit_Valid, then 8'hFF odd
    PAR_TYP = 2'b01;
    rx_start();
    send_bits(9'h0FF, 4);
    Rx_Start = 1'b1; Bit_Valid = 1'b1; Bit_In = 1'b1;
    tick();
    Rx_Start = 1'b0; Bit_Valid = 1'b0;
    send_bits(9'h0FF, 8);
    check("rx5_not_done_early", done8, 1'b0);
    check("rx5_busy", busy8, 1'b1);
    rx_bit(1'b1);
    check("rx5_done", done8, 1'b1);
    check("rx5_err", err8, 1'b0);
    tick();
    check("rx5_single_done", done8, 1'b0);

    // Counter termination across widths, no parity
    PAR_EN = 1'b0;
    rx_start();
    for (int unsigned k = 1; k <= 9; k++) begin
      rx_bit(1'b1);
      check($sformatf("term_w5_b%0d", k), done5, (k == 5));
      check($sformatf("term_w8_b%0d", k), done8, (k == 8));
      check($sformatf("term_w9_b%0d", k), done9, (k == 9));
    end

    // Parity check across widths: nine ones then a 0
    PAR_EN = 1'b1; PAR_TYP = 2'b00;
    rx_start();
    send_bits(9'h1FF, 9);
    rx_bit(1'b0);
    check("w9_done", done9, 1'b1);
    check("w9_err", err9, 1'b1);
    check("w5_err", err5, 1'b0);

    // TX across widths
    DATA_IN5 = 5'h13; DATA_IN9 = 9'h101;
    tx_load(8'h00, 1'b1, 2'b00);
    check("w5_tx", pb5, 1'b1);
    check("w9_tx", pb9, 1'b0);

    // Async reset while waiting for the parity bit
    tx_load(8'h00, 1'b1, 2'b10);
    check("rst6_pb_pre", pb8, 1'b1);
    rx_start();
    send_bits(9'h037, 8);
    check("rst6_busy_pre", busy8, 1'b1);
    RST = 1'b0;
    #1;
    check("rst6_busy", busy8, 1'b0);
    check("rst6_err", err8, 1'b0);
    check("rst6_done", done8, 1'b0);
    check("rst6_pb", pb8, 1'b0);
    tick();
    RST = 1'b1;
    for (int unsigned k = 0; k < 5; k++) begin
      rx_bit(1'b1);
      check($sformatf("rst6_ignore_done_%0d", k), done8, 1'b0);
      check($sformatf("rst6_ignore_busy_%0d", k), busy8, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_parity_unit.md
Name: uart_parity_unit

Overview:
Parametrised parity block shared by the UART transmitter and receiver.
- TX side: latches a parallel data word and presents the parity bit for the serializer, with selectable parity type.
- RX side: accumulates parity serially as the deserializer samples data bits, then checks the received parity bit and flags errors.
- Frame width and parity mode are snapshotted per frame, so mid-frame configuration changes are harmless.

Parameters:
DATA_WIDTH, 8, number of data bits per frame; legal range 5..9.
CNT_WIDTH, 4, width of the RX bit counter; must satisfy 2^CNT_WIDTH > DATA_WIDTH.

Ports:
CLK  input  1  system clock, rising edge.
RST  input  1  asynchronous active-low reset.
PAR_EN  input  1  parity enable; 0 = frame carries no parity bit.
PAR_TYP  input  2  parity type: 00 even, 01 odd, 10 mark (always 1), 11 space (always 0).
Load  input  1  TX strobe: latch DATA_IN and the parity config.
DATA_IN  input  DATA_WIDTH  TX parallel data word.
Parity_Bit  output  1  TX parity bit for the latched word and config.
Rx_Start  input  1  RX strobe: start-bit detected, begin a new frame.
Bit_Valid  input  1  RX strobe: Bit_In holds a sampled bit this cycle.
Bit_In  input  1  RX sampled serial bit.
Par_Err  output  1  RX parity mismatch; registered, holds until the next Rx_Start or reset.
Check_Done  output  1  RX one-cycle pulse: frame check complete.
Rx_Busy  output  1  RX FSM is not IDLE.

Behaviour:
- Reset (RST=0, async), all storage cleared:
  - TX data register = 0, TX mode = {en 0, even}, so Parity_Bit = 0.
  - RX state = IDLE, accumulator = 0, counter = 0.
  - Par_Err = 0, Check_Done = 0, Rx_Busy = 0.
- Expected parity function exp(x, typ), where x is the XOR of all data bits:
  - even = x; odd = ~x; mark = 1; space = 0.
- TX path:
  - On a Load cycle, DATA_IN, PAR_EN and PAR_TYP are registered. Otherwise they hold.
  - Parity_Bit is combinational from the registers, valid the cycle after Load (latency 1).
  - Parity_Bit = exp(^data_reg, typ_reg) when en_reg=1; 0 when en_reg=0.
  - Changes to PAR_TYP or PAR_EN without Load do not affect Parity_Bit.
- RX FSM, states IDLE, DATA, PARITY:
  - IDLE: on Rx_Start, snapshot PAR_EN/PAR_TYP, clear accumulator, counter and Par_Err, go to DATA. Bit_Valid is ignored in IDLE.
  - DATA: on each Bit_Valid, acc <= acc ^ Bit_In and cnt <= cnt+1.
    - On the Bit_Valid that makes cnt == DATA_WIDTH: if en_snap=1, go to PARITY. Otherwise pulse Check_Done next cycle with Par_Err=0 and go to IDLE.
  - PARITY: on Bit_Valid, Par_Err <= (Bit_In != exp(acc, typ_snap)), Check_Done pulses 1 cycle, go to IDLE.
  - Rx_Busy = 1 in DATA and PARITY.
- Boundary conditions:
  - Rx_Start in any state, including with Bit_Valid in the same cycle, restarts the frame. Rx_Start has priority, and that Bit_Valid is discarded.
  - Rx_Start in the same cycle as a PARITY check completion: restart wins, no Check_Done pulse, and Par_Err is cleared.
  - Load and RX activity are independent. Simultaneous Load/Rx_Start are both honoured.
  - Bit_Valid held high for consecutive cycles counts one bit per cycle.
  - The counter never wraps. Leaving DATA at cnt == DATA_WIDTH bounds it.
  - Async reset mid-frame returns to IDLE immediately with all outputs 0. No Check_Done is emitted.
- Check_Done is registered and high for exactly one CLK cycle per completed frame.

Test Plan:
1. DATA_WIDTH=8, PAR_EN=1, PAR_TYP=00, Load DATA_IN=8'hA5 -> Parity_Bit=0 next cycle. Then switch PAR_TYP=01 without Load -> Parity_Bit stays 0. Load again -> Parity_Bit=1.
2. PAR_TYP=10 and 11 with DATA_IN=8'h00 -> Parity_Bit=1 and 0 respectively. PAR_EN=0 with any data -> Parity_Bit=0.
3. RX even parity: Rx_Start, 8 Bit_Valid with bits LSB-first of 8'h37 (popcount 5), parity bit 1 -> Check_Done pulse, Par_Err=0. Repeat with parity bit 0 -> Par_Err=1, held until the next Rx_Start.
4. RX with PAR_EN=0 at Rx_Start (then PAR_EN raised mid-frame) -> Check_Done pulse one cycle after the 8th Bit_Valid, Par_Err=0, no PARITY state entered.
5. Rx_Start asserted after 4 data bits -> accumulator/counter restart. Full 8-bit frame 8'hFF odd with parity bit 1 -> Par_Err=0, exactly one Check_Done.
6. RST pulled low during PARITY state -> Rx_Busy, Par_Err, Check_Done, Parity_Bit all 0 asynchronously. After release, Bit_Valid pulses are ignored until Rx_Start. Rerun with DATA_WIDTH=5 and 9 to confirm counter termination.
